// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the next-PC controller
package pc_ctrl_pkg;

  // Numeric order is the arbitration priority: a larger value always wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BP   = 2'd1,
    SRC_BRU  = 2'd2,
    SRC_EXCP = 2'd3
  } redirect_src_t;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_PEND,
    ST_FLUSH
  } pc_state_t;

  // Two 4-byte slots are fetched per cycle.
  localparam logic [31:0] FETCH_STRIDE = 32'd8;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// rtl/redirect_prio_sel.sv - fixed-priority picker for the three redirect sources
// Ports:
//   excp_valid/excp_target  exception or ertn request (highest priority)
//   bru_valid/bru_target    backend branch resolution request
//   bp_valid/bp_target      front-end predictor request (lowest priority)
//   valid                   some request is present this cycle
//   src                     winning source (SRC_NONE when idle)
//   target                  winning target with bits [1:0] cleared
module redirect_prio_sel
  import pc_ctrl_pkg::*;
(
  input  logic          excp_valid,
  input  logic [31:0]   excp_target,
  input  logic          bru_valid,
  input  logic [31:0]   bru_target,
  input  logic          bp_valid,
  input  logic [31:0]   bp_target,
  output logic          valid,
  output redirect_src_t src,
  output logic [31:0]   target
);

  always_comb begin
    valid  = 1'b1;
    src    = SRC_NONE;
    target = 32'h0;
    if (excp_valid) begin
      src    = SRC_EXCP;
      target = align_word(excp_target);
    end else if (bru_valid) begin
      src    = SRC_BRU;
      target = align_word(bru_target);
    end else if (bp_valid) begin
      src    = SRC_BP;
      target = align_word(bp_target);
    end else begin
      valid  = 1'b0;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - dual-slot next-PC sequencer with redirect arbitration
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pause[5:0]               pipeline pause vector; bit 0 stalls fetch
//   excp_redirect_i/target   exception/ertn redirect pulse and target
//   bru_redirect_i/target    backend mispredict redirect pulse and target
//   bp_redirect_i/target     predictor taken redirect pulse and target
//   pc_1_o, pc_2_o           slot fetch PCs (pc_2_o = aligned pc_1_o + 4)
//   inst_en_1_o/inst_en_2_o  slot fetch enables (always equal)
//   flush_o                  pulses when pc_1_o first shows an excp/bru target
//   pend_valid_o             a redirect is buffered behind a fetch stall
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  pause,
  input  logic        excp_redirect_i,
  input  logic [31:0] excp_target_i,
  input  logic        bru_redirect_i,
  input  logic [31:0] bru_target_i,
  input  logic        bp_redirect_i,
  input  logic [31:0] bp_target_i,
  output logic [31:0] pc_1_o,
  output logic [31:0] pc_2_o,
  output logic        inst_en_1_o,
  output logic        inst_en_2_o,
  output logic        flush_o,
  output logic        pend_valid_o
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam bit         HAS_BUBBLE = (FLUSH_CYCLES != 0);

  pc_state_t     state, state_n;
  redirect_src_t pend_src, pend_src_n;
  logic [31:0]   pend_target, pend_target_n;
  logic [2:0]    flush_cnt, flush_cnt_n;
  logic [31:0]   pc_n;
  logic          en_n, flush_n;

  logic          sel_valid;
  redirect_src_t sel_src;
  logic [31:0]   sel_target;

  // Request to steer the PC this cycle, shared by RUN and PEND.
  logic          do_apply;
  redirect_src_t apply_src;
  logic [31:0]   apply_target;
  redirect_src_t cand_src;
  logic [31:0]   cand_target;

  logic unused_pause;
  assign unused_pause = ^pause[5:1];

  redirect_prio_sel u_prio_sel (
    .excp_valid  (excp_redirect_i),
    .excp_target (excp_target_i),
    .bru_valid   (bru_redirect_i),
    .bru_target  (bru_target_i),
    .bp_valid    (bp_redirect_i),
    .bp_target   (bp_target_i),
    .valid       (sel_valid),
    .src         (sel_src),
    .target      (sel_target)
  );

  always_comb begin
    state_n       = state;
    pend_src_n    = pend_src;
    pend_target_n = pend_target;
    flush_cnt_n   = flush_cnt;
    pc_n          = pc_1_o;
    en_n          = inst_en_1_o;
    flush_n       = 1'b0;
    do_apply      = 1'b0;
    apply_src     = SRC_NONE;
    apply_target  = 32'h0;
    cand_src      = pend_src;
    cand_target   = pend_target;

    case (state)
      ST_BOOT: begin
        // PC is left untouched so RESET_PC is the first address fetched.
        state_n = ST_RUN;
        en_n    = 1'b1;
      end
      ST_RUN: begin
        if (pause[0]) begin
          if (sel_valid) begin
            pend_src_n    = sel_src;
            pend_target_n = sel_target;
            state_n       = ST_PEND;
          end
        end else if (sel_valid) begin
          do_apply     = 1'b1;
          apply_src    = sel_src;
          apply_target = sel_target;
        end else begin
          pc_n = pc_1_o + FETCH_STRIDE;
        end
      end
      ST_PEND: begin
        // Equal priority replaces: the newest request of a class is the valid one.
        if (sel_valid && (sel_src >= pend_src)) begin
          cand_src    = sel_src;
          cand_target = sel_target;
        end
        if (pause[0]) begin
          pend_src_n    = cand_src;
          pend_target_n = cand_target;
        end else begin
          do_apply      = 1'b1;
          apply_src     = cand_src;
          apply_target  = cand_target;
          pend_src_n    = SRC_NONE;
          pend_target_n = 32'h0;
        end
      end
      ST_FLUSH: begin
        // Predictor redirects here belong to the squashed path and are dropped.
        if (sel_valid && (sel_src >= SRC_BRU)) begin
          pc_n        = sel_target;
          flush_n     = 1'b1;
          flush_cnt_n = FLUSH_LOAD;
        end else if (flush_cnt == 3'd1) begin
          state_n     = ST_RUN;
          en_n        = 1'b1;
          flush_cnt_n = 3'd0;
        end else begin
          flush_cnt_n = flush_cnt - 3'd1;
        end
      end
      default: state_n = ST_BOOT;
    endcase

    if (do_apply) begin
      pc_n    = apply_target;
      state_n = ST_RUN;
      en_n    = 1'b1;
      if (apply_src >= SRC_BRU) begin
        flush_n = 1'b1;
        if (HAS_BUBBLE) begin
          en_n        = 1'b0;
          flush_cnt_n = FLUSH_LOAD;
          state_n     = ST_FLUSH;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_BOOT;
      pend_src     <= SRC_NONE;
      pend_target  <= 32'h0;
      flush_cnt    <= 3'd0;
      pc_1_o       <= RESET_PC;
      pc_2_o       <= align_word(RESET_PC) + 32'd4;
      inst_en_1_o  <= 1'b0;
      inst_en_2_o  <= 1'b0;
      flush_o      <= 1'b0;
      pend_valid_o <= 1'b0;
    end else begin
      state        <= state_n;
      pend_src     <= pend_src_n;
      pend_target  <= pend_target_n;
      flush_cnt    <= flush_cnt_n;
      pc_1_o       <= pc_n;
      pc_2_o       <= align_word(pc_n) + 32'd4;
      inst_en_1_o  <= en_n;
      inst_en_2_o  <= en_n;
      flush_o      <= flush_n;
      pend_valid_o <= (state_n == ST_PEND);
    end
  end

endmodule
